// File: rtl/hb_rwds_wr_drv_pkg.sv
// Shared HyperBus controller definitions used by the RWDS write driver.
// Holds the write-path FSM encoding and the RWDS mask polarity.
package hb_rwds_wr_drv_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_PRE  = 2'd1,
        ST_DATA = 2'd2,
        ST_POST = 2'd3
    } hb_wr_state_e;

    localparam logic MASK_ON  = 1'b1;
    localparam logic MASK_OFF = 1'b0;

    localparam logic [1:0] SDR_DRIVE_LOW  = {MASK_OFF, MASK_OFF};
    localparam logic [1:0] SDR_ALL_MASKED = {MASK_ON, MASK_ON};

    // strb[1] is the posedge byte and lands in sdr[0]
    function automatic logic [1:0] strb_to_mask(input logic [1:0] strb);
        return {strb[0] ? MASK_OFF : MASK_ON,
                strb[1] ? MASK_OFF : MASK_ON};
    endfunction

endpackage

// File: rtl/hb_rwds_wr_drv.sv
// Write-path RWDS driver: preamble, per-word data mask and postamble,
// registered for the RWDS ODDR stage; RWDS released at all other times.
module hb_rwds_wr_drv #(
    parameter int LEN_WIDTH       = 16,
    parameter int PREAMBLE_CYCLES = 1
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 cmd_valid,
    output logic                 cmd_ready,
    input  logic [LEN_WIDTH-1:0] cmd_len,
    input  logic                 strb_valid,
    output logic                 strb_ready,
    input  logic [1:0]           strb,
    input  logic                 abort,
    output logic [1:0]           rwds_sdr,
    output logic                 rwds_t,
    output logic                 busy,
    output logic                 done,
    output logic                 err_underrun
);
    import hb_rwds_wr_drv_pkg::*;

    localparam logic [3:0] PRE_INIT = 4'(PREAMBLE_CYCLES - 1);
    localparam logic [LEN_WIDTH-1:0] ONE = LEN_WIDTH'(1);

    hb_wr_state_e         state_q, state_d;
    logic [3:0]           pre_cnt_q, pre_cnt_d;
    logic [LEN_WIDTH-1:0] word_cnt_q, word_cnt_d;
    logic [LEN_WIDTH-1:0] len_q, len_d;
    logic [1:0]           rwds_sdr_q, rwds_sdr_d;
    logic                 rwds_t_q, rwds_t_d;
    logic                 done_q, done_d;
    logic                 err_q, err_d;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= ST_IDLE;
            pre_cnt_q  <= '0;
            word_cnt_q <= '0;
            len_q      <= '0;
            rwds_sdr_q <= SDR_DRIVE_LOW;
            rwds_t_q   <= 1'b1;
            done_q     <= 1'b0;
            err_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            pre_cnt_q  <= pre_cnt_d;
            word_cnt_q <= word_cnt_d;
            len_q      <= len_d;
            rwds_sdr_q <= rwds_sdr_d;
            rwds_t_q   <= rwds_t_d;
            done_q     <= done_d;
            err_q      <= err_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        pre_cnt_d  = pre_cnt_q;
        word_cnt_d = word_cnt_q;
        len_d      = len_q;
        unique case (state_q)
            ST_IDLE: begin
                if (cmd_valid) begin
                    len_d = cmd_len;
                    if (cmd_len != '0) begin
                        state_d   = ST_PRE;
                        pre_cnt_d = PRE_INIT;
                    end
                end
            end
            ST_PRE: begin
                if (pre_cnt_q == '0) begin
                    state_d    = ST_DATA;
                    word_cnt_d = len_q - ONE;
                end else begin
                    pre_cnt_d = pre_cnt_q - 4'd1;
                end
            end
            ST_DATA: begin
                if (word_cnt_q == '0) begin
                    state_d = ST_POST;
                end else begin
                    word_cnt_d = word_cnt_q - ONE;
                end
            end
            ST_POST: state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
        if (abort && state_q != ST_IDLE) begin
            state_d = ST_IDLE;
        end
    end

    // Registered outputs follow the next state so they align with it
    always_comb begin
        cmd_ready  = (state_q == ST_IDLE);
        strb_ready = (state_q == ST_DATA);
        busy       = (state_q != ST_IDLE);
        rwds_t_d   = (state_d == ST_IDLE);
        rwds_sdr_d = SDR_DRIVE_LOW;
        err_d      = 1'b0;
        if (state_d == ST_DATA) begin
            rwds_sdr_d = strb_valid ? strb_to_mask(strb)
                                    : SDR_ALL_MASKED;
            err_d      = ~strb_valid;
        end
        done_d = (state_q == ST_POST && !abort)
              || (state_q == ST_IDLE && cmd_valid && cmd_len == '0);
    end

    assign rwds_sdr     = rwds_sdr_q;
    assign rwds_t       = rwds_t_q;
    assign done         = done_q;
    assign err_underrun = err_q;

endmodule

// File: tb/tb_hb_rwds_wr_drv.sv
// Directed scoreboard bench for the RWDS write driver.
module tb_hb_rwds_wr_drv;

    localparam int LW = 16;
    localparam int P  = 1;

    logic          clk = 1'b0;
    logic          rst;
    logic          cmd_valid;
    logic          cmd_ready;
    logic [LW-1:0] cmd_len;
    logic          strb_valid;
    logic          strb_ready;
    logic [1:0]    strb;
    logic          abort;
    logic [1:0]    rwds_sdr;
    logic          rwds_t;
    logic          busy;
    logic          done;
    logic          err_underrun;

    hb_rwds_wr_drv #(
        .LEN_WIDTH      (LW),
        .PREAMBLE_CYCLES(P)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .cmd_valid   (cmd_valid),
        .cmd_ready   (cmd_ready),
        .cmd_len     (cmd_len),
        .strb_valid  (strb_valid),
        .strb_ready  (strb_ready),
        .strb        (strb),
        .abort       (abort),
        .rwds_sdr    (rwds_sdr),
        .rwds_t      (rwds_t),
        .busy        (busy),
        .done        (done),
        .err_underrun(err_underrun)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic       t;
        logic [1:0] sdr;
        logic       done;
        logic       err;
        logic       busy;
        logic       crdy;
        logic       srdy;
    } exp_t;

    exp_t       sb[$];
    int         errors = 0;
    int         checks = 0;
    logic [1:0] st[16];
    logic       sv[16];

    task automatic chk(input string tag, input logic [1:0] obs,
                       input logic [1:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%b expected=%b", tag, obs, exp);
        end
    endtask

    function automatic exp_t idle_e();
        exp_t e;
        e      = '0;
        e.t    = 1'b1;
        e.crdy = 1'b1;
        return e;
    endfunction

    // Expected outputs in the j-th cycle after the handshake edge
    function automatic exp_t exp_at(input int j, input int len);
        exp_t e;
        int   k;
        e = '0;
        if (len == 0 || j > P + len) begin
            e      = idle_e();
            e.done = 1'b1;
        end else if (j < P || j == P + len) begin
            e.busy = 1'b1;
        end else begin
            k      = j - P;
            e.busy = 1'b1;
            e.srdy = 1'b1;
            e.sdr  = sv[k] ? {~st[k][0], ~st[k][1]} : 2'b11;
            e.err  = ~sv[k];
        end
        return e;
    endfunction

    task automatic tick(input string tag);
        exp_t e;
        @(posedge clk);
        @(negedge clk);
        checks++;
        assert (sb.size() != 0) else begin
            errors++;
            $error("FAIL %s_sb: observed=empty expected=entry", tag);
        end
        if (sb.size() != 0) begin
            e = sb.pop_front();
            chk({tag, "_rwds_t"}, {1'b0, rwds_t}, {1'b0, e.t});
            chk({tag, "_sdr"}, rwds_sdr, e.sdr);
            chk({tag, "_done"}, {1'b0, done}, {1'b0, e.done});
            chk({tag, "_err"}, {1'b0, err_underrun}, {1'b0, e.err});
            chk({tag, "_busy"}, {1'b0, busy}, {1'b0, e.busy});
            chk({tag, "_crdy"}, {1'b0, cmd_ready}, {1'b0, e.crdy});
            chk({tag, "_srdy"}, {1'b0, strb_ready}, {1'b0, e.srdy});
        end
    endtask

    // Called at a negedge in IDLE; returns at the negedge of the
    // done cycle (or the idle cycle after an abort).
    task automatic burst(input string tag, input int len,
                         input int abort_j, input bit hold);
        int total;
        int k;
        total     = (len == 0) ? 1 : P + len + 2;
        cmd_valid = 1'b1;
        cmd_len   = LW'(len);
        sb.push_back(exp_at(0, len));
        tick(tag);
        if (!hold) cmd_valid = 1'b0;
        for (int j = 0; j < total - 1; j++) begin
            k = j + 1 - P;
            if (k >= 0 && k < len) begin
                strb_valid = sv[k];
                strb       = st[k];
            end else begin
                strb_valid = 1'b0;
                strb       = 2'b00;
            end
            if (j == abort_j) begin
                abort = 1'b1;
                sb.push_back(idle_e());
                tick({tag, "_abt"});
                abort      = 1'b0;
                strb_valid = 1'b0;
                return;
            end
            sb.push_back(exp_at(j + 1, len));
            tick(tag);
        end
        strb_valid = 1'b0;
    endtask

    task automatic idle_tick(input string tag);
        sb.push_back(idle_e());
        tick(tag);
    endtask

    initial begin
        cmd_valid  = 1'b0;
        cmd_len    = '0;
        strb_valid = 1'b0;
        strb       = 2'b00;
        abort      = 1'b0;
        rst        = 1'b0;
        #1 rst = 1'b1;
        #1;
        chk("rst_t", {1'b0, rwds_t}, 2'b01);
        chk("rst_sdr", rwds_sdr, 2'b00);
        chk("rst_done", {1'b0, done}, 2'b00);
        chk("rst_err", {1'b0, err_underrun}, 2'b00);
        chk("rst_busy", {1'b0, busy}, 2'b00);
        @(negedge clk);
        rst = 1'b0;
        idle_tick("idle0");

        st[0] = 2'b11; st[1] = 2'b10; st[2] = 2'b01; st[3] = 2'b00;
        for (int i = 0; i < 4; i++) sv[i] = 1'b1;
        burst("len4", 4, -1, 1'b0);
        idle_tick("idle1");

        st[0] = 2'b10; st[1] = 2'b11; st[2] = 2'b01;
        sv[0] = 1'b1; sv[1] = 1'b0; sv[2] = 1'b1;
        burst("undr", 3, -1, 1'b0);
        idle_tick("idle2");

        burst("len0", 0, -1, 1'b0);
        idle_tick("len0_after");

        for (int i = 0; i < 8; i++) begin
            st[i] = 2'($urandom_range(0, 3));
            sv[i] = 1'b1;
        end
        burst("abort8", 8, P + 1, 1'b0);
        st[0] = 2'b01; sv[0] = 1'b1;
        burst("post_abt", 1, -1, 1'b0);
        idle_tick("idle3");

        st[0] = 2'b11; st[1] = 2'b10; sv[0] = 1'b1; sv[1] = 1'b1;
        burst("b2b_a", 2, -1, 1'b1);
        st[0] = 2'b01; st[1] = 2'b00;
        burst("b2b_b", 2, -1, 1'b0);
        idle_tick("idle4");

        for (int i = 0; i < 6; i++) begin
            st[i] = 2'($urandom_range(0, 3));
            sv[i] = 1'($urandom_range(0, 1));
        end
        burst("rand6", 6, -1, 1'b0);
        idle_tick("idle5");

        // Reset in the middle of DATA: release must not wait for clk
        st[0] = 2'b00; st[1] = 2'b00; sv[0] = 1'b1; sv[1] = 1'b1;
        cmd_valid = 1'b1;
        cmd_len   = LW'(4);
        sb.push_back(exp_at(0, 4));
        tick("mrst_pre");
        cmd_valid  = 1'b0;
        strb_valid = sv[0];
        strb       = st[0];
        sb.push_back(exp_at(1, 4));
        tick("mrst_d0");
        #1 rst = 1'b1;
        #1;
        chk("mrst_t", {1'b0, rwds_t}, 2'b01);
        chk("mrst_sdr", rwds_sdr, 2'b00);
        chk("mrst_busy", {1'b0, busy}, 2'b00);
        chk("mrst_done", {1'b0, done}, 2'b00);
        strb_valid = 1'b0;
        @(negedge clk);
        rst = 1'b0;
        idle_tick("mrst_idle");

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
